// File: rtl/sort_pkg.sv
// Shared word geometry, controller states and the signed-key ordering used by the
// odd-even transposition sorter.
package sort_pkg;

  localparam int unsigned W       = 14;
  localparam int unsigned KEY_MSB = 8;

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  // True when key(a) > key(b); keys are two's complement in [KEY_MSB:0].
  function automatic logic key_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a[KEY_MSB] != b[KEY_MSB]) begin
      return b[KEY_MSB];
    end
    return a[KEY_MSB:0] > b[KEY_MSB:0];
  endfunction

endpackage

// File: rtl/sort_cmp_stage.sv
// One odd-even transposition phase: N/2 compare-swap cells on adjacent pairs whose
// starting index parity is chosen by i_odd.
module sort_cmp_stage
  import sort_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           i_odd,
  input  logic [N*W-1:0] i_words,
  output logic [N*W-1:0] o_words
);

  always_comb begin
    int lo;
    lo      = 0;
    o_words = i_words;
    for (int k = 0; k < int'(N / 2); k++) begin
      lo = 2 * k + int'(i_odd);
      // Strict compare keeps equal keys in arrival order.
      if (lo + 1 < int'(N)) begin
        if (key_gt(i_words[lo*W +: W], i_words[(lo+1)*W +: W])) begin
          o_words[lo*W +: W]     = i_words[(lo+1)*W +: W];
          o_words[(lo+1)*W +: W] = i_words[lo*W +: W];
        end
      end
    end
  end

endmodule

// File: rtl/sort_oets_ctrl.sv
// Batch sort controller: loads N words, runs N odd-even transposition phases over one bank,
// then streams the bank out in ascending signed-key order with valid/ready backpressure.
module sort_oets_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_out_last,
  output logic         o_busy
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned IW = $clog2(N);
  localparam logic [CW-1:0] LastIdx = CW'(N - 1);

  state_e        r_state;
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;
  logic [CW-1:0] r_phase;
  logic [W-1:0]  r_bank [N];
  logic          r_in_ready;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_out_last;
  logic          r_busy;

  logic [N*W-1:0] w_bank_flat;
  logic [N*W-1:0] w_sorted_flat;
  logic [CW-1:0]  w_rd_next;

  always_comb begin
    w_bank_flat = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_bank_flat[i*W +: W] = r_bank[i];
    end
  end

  assign w_rd_next = r_rd_cnt + CW'(1);

  sort_cmp_stage #(
    .N (N)
  ) u_stage (
    .i_odd   (r_phase[0]),
    .i_words (w_bank_flat),
    .o_words (w_sorted_flat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StLoad;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_phase     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StLoad: begin
          if (i_in_valid && r_in_ready) begin
            r_bank[r_wr_cnt[IW-1:0]] <= i_in_data;
            if (r_wr_cnt == LastIdx) begin
              r_state    <= StSort;
              r_wr_cnt   <= '0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_wr_cnt <= r_wr_cnt + CW'(1);
            end
          end
        end
        StSort: begin
          for (int i = 0; i < int'(N); i++) begin
            r_bank[i] <= w_sorted_flat[i*W +: W];
          end
          if (r_phase == LastIdx) begin
            r_state <= StDrain;
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + CW'(1);
          end
        end
        StDrain: begin
          // r_rd_cnt always names the word currently presented on o_out_data.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_bank[r_rd_cnt[IW-1:0]];
            r_out_last  <= (r_rd_cnt == LastIdx);
          end else if (i_out_ready) begin
            if (r_out_last) begin
              r_state     <= StLoad;
              r_rd_cnt    <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_rd_cnt   <= w_rd_next;
              r_out_data <= r_bank[w_rd_next[IW-1:0]];
              r_out_last <= (w_rd_next == LastIdx);
            end
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_sort_oets_ctrl.sv
// Directed bench for sort_oets_ctrl: table of batches with hand-sorted expectations,
// plus a mid-sort reset sequence.
module tb_sort_oets_ctrl;
  import sort_pkg::*;

  localparam int N = 8;

  typedef struct packed {
    logic [111:0] din;
    logic [111:0] dexp;
    logic [6:0]   stall;
    logic         hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [13:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [13:0] out_data;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  sort_oets_ctrl #(
    .N (N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_busy      (busy)
  );

  function automatic logic [111:0] w8(input logic [13:0] a0, input logic [13:0] a1,
                                      input logic [13:0] a2, input logic [13:0] a3,
                                      input logic [13:0] a4, input logic [13:0] a5,
                                      input logic [13:0] a6, input logic [13:0] a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_batch(input vec_t v);
    logic [13:0] prev_data;
    logic        prev_stall;
    int          idx;
    int          cyc;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("in_ready_load", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = v.din[i*14 +: 14];
    end
    @(posedge clk);
    #1;
    chk("busy_after_load", 32'(busy), 32'd1);
    chk("in_ready_after_load", 32'(in_ready), 32'd0);
    if (v.hold) in_data = 14'h3FFF;
    else in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(N + 1));
    idx        = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (idx < N && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) chk("hold_data", 32'(out_data), 32'(prev_data));
      out_ready = ($urandom_range(99) >= 32'(v.stall));
      if (out_valid && out_ready) begin
        chk("out_data", 32'(out_data), 32'(v.dexp[idx*14 +: 14]));
        chk("out_last", 32'(out_last), 32'(idx == N - 1));
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    chk("drain_count", 32'(idx), 32'(N));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0].din  = w8(14'h007, 14'h006, 14'h005, 14'h004, 14'h003, 14'h002, 14'h001, 14'h000);
    vecs[0].dexp = w8(14'h000, 14'h001, 14'h002, 14'h003, 14'h004, 14'h005, 14'h006, 14'h007);
    vecs[0].stall = 7'd0;
    vecs[0].hold  = 1'b0;
    vecs[1].din  = w8(14'h0FF, 14'h100, 14'h1FF, 14'h000, 14'h001, 14'h180, 14'h07F, 14'h101);
    vecs[1].dexp = w8(14'h100, 14'h101, 14'h180, 14'h1FF, 14'h000, 14'h001, 14'h07F, 14'h0FF);
    vecs[1].stall = 7'd0;
    vecs[1].hold  = 1'b0;
    vecs[2].din  = w8(14'h005, 14'h205, 14'h405, 14'h605, 14'h805, 14'hA05, 14'hC05, 14'hE05);
    vecs[2].dexp = w8(14'h005, 14'h205, 14'h405, 14'h605, 14'h805, 14'hA05, 14'hC05, 14'hE05);
    vecs[2].stall = 7'd0;
    vecs[2].hold  = 1'b0;
    vecs[3].din  = w8(14'h203, 14'h5F0, 14'h603, 14'h850, 14'hB00, 14'hC00, 14'hFF0, 14'h0FF);
    vecs[3].dexp = w8(14'hB00, 14'h5F0, 14'hFF0, 14'hC00, 14'h203, 14'h603, 14'h850, 14'h0FF);
    vecs[3].stall = 7'd30;
    vecs[3].hold  = 1'b0;
    vecs[4]       = vecs[1];
    vecs[4].stall = 7'd30;
    vecs[4].hold  = 1'b1;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_batch(vecs[v]);
    end

    // Reset during phase 3 of a batch, then a fresh batch must sort cleanly.
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[3].din[i*14 +: 14];
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_batch(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
